bcd_to_bin_serial: RTL

- Digit-serial converter from packed BCD to unsigned binary, in the reverse direction of the BCD adder datapath.
- Accepts a BCD sum in adder format: carry bit above DIGITS packed digits, MSD highest.
- Returns the binary equivalent, with an error flag for non-decimal digits.
- Uses a valid/ready handshake on both sides. Sits between the BCD arithmetic blocks and binary consumers such as comparators and counters.

---
 rtl/bcd_to_bin_serial_if.sv | 24 ++
 rtl/bcd_to_bin_serial.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_serial_if.sv
// Handshake bundle for bcd_to_bin_serial: BCD source side (in_*) and
// binary consumer side (out_*). The slave modport is the converter's view.
interface bcd_to_bin_serial_if #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned BIN_W  = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS:0]   in_bcd;
    logic                out_valid;
    logic                out_ready;
    logic [BIN_W-1:0]    out_bin;
    logic                out_err;

    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_bin, out_err
    );

    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_bin, out_err
    );
endinterface

// File: rtl/bcd_to_bin_serial.sv
// Digit-serial packed-BCD (with carry above the MSD) to unsigned binary
// converter. One digit is folded in per cycle as acc = acc*10 + digit.
// Optional macro BCD2BIN_ERR_CNT_EN adds a saturating 8-bit count of
// accepted inputs that contained a non-decimal digit.
module bcd_to_bin_serial #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned BIN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef BCD2BIN_ERR_CNT_EN
    output logic [7:0]            err_count,
`endif
    bcd_to_bin_serial_if.slave    bus
);

    localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [BIN_W-1:0]    acc_q, acc_d;
    logic [4*DIGITS-1:0] shreg_q, shreg_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [BIN_W-1:0]    out_bin_q, out_bin_d;
    logic                out_err_q, out_err_d;

    logic                accept;
    logic                digit_err;
    logic [BIN_W-1:0]    acc_step;

    // Any packed digit above 9; the carry bit is never checked.
    always_comb begin
        digit_err = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.in_bcd[4*i +: 4] > 4'd9) begin
                digit_err = 1'b1;
            end
        end
    end

    assign accept   = bus.in_valid & bus.in_ready;
    assign acc_step = (acc_q << 3) + (acc_q << 1) + BIN_W'(shreg_q[4*DIGITS-1 -: 4]);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CONV;
                end
            end
            CONV: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = accept ? CONV : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
        bus.out_valid = (state_q == DONE);
    end

    // Datapath next values; result registers load only when leaving CONV.
    always_comb begin
        acc_d     = acc_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        out_bin_d = out_bin_q;
        out_err_d = out_err_q;
        if (accept) begin
            acc_d   = BIN_W'(bus.in_bcd[4*DIGITS]);
            shreg_d = bus.in_bcd[4*DIGITS-1:0];
            cnt_d   = CW'(DIGITS - 1);
            err_d   = digit_err;
        end else if (state_q == CONV) begin
            acc_d   = acc_step;
            shreg_d = shreg_q << 4;
            if (cnt_q == '0) begin
                out_bin_d = err_q ? '0 : acc_step;
                out_err_d = err_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            shreg_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            out_bin_q <= '0;
            out_err_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            out_bin_q <= out_bin_d;
            out_err_q <= out_err_d;
        end
    end

    assign bus.out_bin = out_bin_q;
    assign bus.out_err = out_err_q;

`ifdef BCD2BIN_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating count of accepted inputs carrying a non-decimal digit.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && digit_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule
